mat_stream_loader: RTL and testbench
====================================

# mat_stream_loader

Byte-stream sequencer wrapped around the combinational 4x4 matrix multiplier in the graphics test path. It collects 32 bytes (matrix A, then matrix B) from an upstream valid/ready stream and presents them as registered 128-bit operands to the multiplier. After a fixed settle time it captures the 128-bit product and streams it back out as 16 bytes with valid/ready/last. It is the block that feeds the multiplier and consumes its product, so the multiplier stays purely combinational.

## Interface
- CALC_CYCLES, 1, cycles the operands are held before the product is captured; legal range 1..15.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte; high only in LOAD_A or LOAD_B.
- keep_a  in  1  sampled on the final output handshake; 1 = reuse the current A and go straight to LOAD_B.
- a_mat  out  128  operand A to multiplier; element [r][c] at bits [127-8*(4r+c) -: 8].
- b_mat  out  128  operand B to multiplier; same packing.
- res_mat  in  128  product from multiplier; same packing.
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  high with the 16th result byte.
- busy  out  1  high in CALC or DRAIN.

## Operation
- States: LOAD_A, LOAD_B, CALC, DRAIN. Reset state is LOAD_A.
- An input transfer happens when in_valid && in_ready.
- Byte counter idx runs 0..15. Byte k is written to bits [127-8k -: 8] of the matrix being loaded, so the first byte is element [0][0] and the order is row-major.
- LOAD_A: each transfer writes into a_mat. On idx==15, clear idx and go to LOAD_B.
- LOAD_B: each transfer writes into b_mat. On idx==15, clear idx and go to CALC.
- CALC:
  - in_ready is 0.
  - The settle counter runs 0..CALC_CYCLES-1.
  - In the last CALC cycle, res_mat is captured into an internal result register and the state goes to DRAIN.
- DRAIN:
  - out_valid is 1, and out_data = result[127-8*idx -: 8].
  - An output transfer (out_valid && out_ready) advances idx.
  - out_last = (idx==15).
  - On the last transfer, clear idx. If keep_a is 1, go to LOAD_B with a_mat retained; otherwise go to LOAD_A.
- a_mat and b_mat are written only by accepted bytes. They hold their values through CALC and DRAIN, and after DRAIN until overwritten.
- Arithmetic belongs to the multiplier: each element is the sum of four 8-bit products, truncated modulo 256. This block does not alter the product. The result register captures exactly res_mat.
- in_valid outside LOAD_A/LOAD_B is ignored.
- out_ready outside DRAIN is ignored.

## Timing
- Reset values:
  - a_mat, b_mat, result register, idx, settle counter: 0.
  - out_valid, out_last, busy: 0.
  - out_data: 0.
  - in_ready: 1, because the state is LOAD_A.
- Reset mid-operation: the partial load or drain is discarded and all of the above values are restored on the next edge.
- Input rate: one byte per cycle at most. in_ready is combinational from the state only, not from in_valid.
- Latency:
  - The 32nd input byte is accepted in cycle t.
  - CALC occupies cycles t+1 .. t+CALC_CYCLES.
  - out_valid first rises in cycle t+1+CALC_CYCLES.
- Output: with out_ready held high, 16 bytes leave on 16 consecutive cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.
- Turnaround: the cycle after the last output handshake, in_ready = 1 (LOAD_A or LOAD_B). No bubble is inserted beyond the state change.
- Operands are registered, so a_mat/b_mat are stable for the full CALC window. The multiplier's combinational path must settle within CALC_CYCLES clock periods.

## Test plan
- Identity × data: A = 01,00,00,00, 00,01,00,00, 00,00,01,00, 00,00,00,01; B = 01..10 hex.
  - Output is 01..10 in order.
  - out_last is high only on byte 10.
  - With CALC_CYCLES=1, out_valid rises 2 cycles after the last input handshake.
- Wrap-around: all A bytes 10, all B bytes 10 -> every output byte is 00 (4×256 mod 256). All A bytes 02, all B bytes 03 -> every output byte is 18.
- Backpressure: random out_ready and random in_valid gaps.
  - Byte order is unchanged and none are dropped.
  - out_data is stable while stalled.
  - in_ready is 0 throughout CALC and DRAIN.
- keep_a: first job A = identity, B = 01..10, with keep_a=1 on the final output.
  - Next, send only 16 bytes of B = all 05.
  - Result is all 05, and the state goes directly to LOAD_B.
- Reset mid-op:
  - Assert rst_n=0 after 20 input bytes, then complete a full identity job.
  - The result is correct, proving the partial data was discarded.
  - Separately, reset during DRAIN -> out_valid is 0 on the next edge and in_ready is 1.
- CALC_CYCLES=4 build: out_valid rises exactly 5 cycles after the last input handshake, and the captured result matches the reference model.

Source files
------------

// File: rtl/mat_stream_loader.sv
// rtl/mat_stream_loader.sv - byte-stream operand loader and result drainer for the 4x4 matrix multiplier
module mat_stream_loader #(
    parameter int CALC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         keep_a,
    output logic [127:0] a_mat,
    output logic [127:0] b_mat,
    input  logic [127:0] res_mat,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        CALC,
        DRAIN
    } state_t;

    localparam logic [3:0] CALC_LAST = 4'(CALC_CYCLES - 1);

    state_t         state_q;
    logic [3:0]     idx_q;
    logic [3:0]     cnt_q;
    logic [127:0]   a_q;
    logic [127:0]   b_q;
    logic [127:0]   res_q;
    logic [7:0]     out_data_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           busy_q;

    logic           in_fire;
    logic [3:0]     idx_d;
    logic [6:0]     byte_shift_d;
    logic [127:0]   byte_mask_d;
    logic [127:0]   byte_ins_d;

    // Byte k of a row-major matrix sits at bits [127-8k -: 8].
    function automatic logic [7:0] byte_at(input logic [127:0] m, input logic [3:0] k);
        logic [127:0] s;
        s = m << {k, 3'b000};
        return s[127:120];
    endfunction

    // Acceptance depends on the state alone so in_ready never loops back from in_valid.
    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign in_fire   = in_valid && in_ready;

    assign a_mat     = a_q;
    assign b_mat     = b_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    // Byte-lane insert for the matrix being loaded; ~idx is 15-idx, the lane counted from the LSB.
    always_comb begin
        idx_d        = idx_q + 4'd1;
        byte_shift_d = {~idx_q, 3'b000};
        byte_mask_d  = ~(128'hFF << byte_shift_d);
        byte_ins_d   = 128'(in_data) << byte_shift_d;
    end

    // Sequencer: load A, load B, hold operands for the settle window, then drain the product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (in_fire) begin
                        a_q   <= (a_q & byte_mask_d) | byte_ins_d;
                        idx_q <= idx_d;
                        if (idx_q == 4'd15) begin
                            state_q <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        b_q   <= (b_q & byte_mask_d) | byte_ins_d;
                        idx_q <= idx_d;
                        if (idx_q == 4'd15) begin
                            state_q <= CALC;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == CALC_LAST) begin
                        cnt_q       <= '0;
                        res_q       <= res_mat;
                        out_data_q  <= res_mat[127:120];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        idx_q <= idx_d;
                        if (idx_q == 4'd15) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= keep_a ? LOAD_B : LOAD_A;
                        end else begin
                            out_data_q <= byte_at(res_q, idx_d);
                            out_last_q <= (idx_q == 4'd14);
                        end
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_loader.sv
// tb/tb_mat_stream_loader.sv - self-checking bench for mat_stream_loader
module tb_mat_stream_loader;

    localparam logic [127:0] ID_MAT   = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] RAMP_MAT = 128'h01020304_05060708_090a0b0c_0d0e0f10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid, in_ready, keep_a;
    logic [127:0] a_mat, b_mat, res_mat;
    logic [7:0]   out_data;
    logic         out_valid, out_ready, out_last, busy;

    logic [7:0]   in_data4;
    logic         in_valid4, in_ready4;
    logic [127:0] a_mat4, b_mat4, res_mat4;
    logic [7:0]   out_data4;
    logic         out_valid4, out_ready4, out_last4, busy4;

    mat_stream_loader #(.CALC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .keep_a(keep_a), .a_mat(a_mat), .b_mat(b_mat), .res_mat(res_mat), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    mat_stream_loader #(.CALC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .keep_a(1'b0), .a_mat(a_mat4), .b_mat(b_mat4), .res_mat(res_mat4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_last(out_last4), .busy(busy4)
    );

    // Multiplier stand-in: sum of four 8-bit products per element, modulo 256.
    function automatic logic [127:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += int'(a[127-8*(4*i+k) -: 8]) * int'(b[127-8*(4*k+j) -: 8]);
                r[127-8*(4*i+j) -: 8] = 8'(s);
            end
        end
        return r;
    endfunction

    always_comb res_mat  = mat_mul(a_mat, b_mat);
    always_comb res_mat4 = mat_mul(a_mat4, b_mat4);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the bytes sent, in plain arrays, and the bytes still owed downstream.
    logic [7:0]   A_m [16];
    logic [7:0]   B_m [16];
    logic [7:0]   exp_q [$];
    int           out_pos    = 0;
    logic [127:0] obs_p      = '0;
    int           last_hs    = 0;
    logic         prev_valid = 1'b0;
    logic         rand_ready = 1'b0;
    logic         gaps       = 1'b0;

    function automatic logic [127:0] model_product();
        logic [127:0] p;
        int s;
        p = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(A_m[4*r+k]) * int'(B_m[4*k+c]);
                p[127-8*(4*r+c) -: 8] = 8'(s % 256);
            end
        end
        return p;
    endfunction

    task automatic push_expected();
        logic [127:0] p;
        p = model_product();
        for (int i = 0; i < 16; i++) exp_q.push_back(p[127-8*i -: 8]);
    endtask

    // Compare process: every cycle out of reset, against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) last_hs = cyc;
            check("in_ready_vs_busy", in_ready, !busy);
            if (out_valid && !prev_valid) check("latency", cyc - last_hs, 2);
            if (out_valid) begin
                check("busy_in_drain", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    check("out_last", out_last, out_pos == 15);
                    if (out_ready) begin
                        obs_p[127-8*out_pos -: 8] = out_data;
                        void'(exp_q.pop_front());
                        out_pos = (out_pos + 1) % 16;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // Downstream ready: held high, or random when backpressure is enabled.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input bit do_a);
        if (do_a) for (int i = 0; i < 16; i++) send_byte(A_m[i]);
        for (int i = 0; i < 16; i++) send_byte(B_m[i]);
        push_expected();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); t++; end
        check("drain_done", exp_q.size() == 0, 1);
        #1;
        check("turnaround_in_ready", in_ready, 1);
        check("turnaround_busy", busy, 0);
    endtask

    task automatic set_id_ramp();
        for (int i = 0; i < 16; i++) begin
            A_m[i] = (i % 5 == 0) ? 8'h01 : 8'h00;
            B_m[i] = 8'(i + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [127:0] obs4;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; keep_a = 1'b0;
        in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_mat", a_mat, '0);
        check("rst_b_mat", b_mat, '0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Identity x ramp
        set_id_ramp();
        load(1);
        check("a_mat_packing", a_mat, ID_MAT);
        check("b_mat_packing", b_mat, RAMP_MAT);
        wait_drain();
        check("id_x_ramp", obs_p, RAMP_MAT);

        // Wrap-around cases
        for (int i = 0; i < 16; i++) begin A_m[i] = 8'h10; B_m[i] = 8'h10; end
        load(1);
        wait_drain();
        check("wrap_10x10", obs_p, 128'h0);
        for (int i = 0; i < 16; i++) begin A_m[i] = 8'h02; B_m[i] = 8'h03; end
        load(1);
        wait_drain();
        check("all_02x03", obs_p, {16{8'h18}});

        // Backpressure with random input gaps
        rand_ready = 1'b1; gaps = 1'b1;
        for (int i = 0; i < 16; i++) begin A_m[i] = 8'($urandom); B_m[i] = 8'($urandom); end
        load(1);
        wait_drain();
        check("backpressure_result", obs_p, model_product());
        rand_ready = 1'b0; gaps = 1'b0;

        // keep_a: reuse identity A, send only B
        set_id_ramp();
        keep_a = 1'b1;
        load(1);
        wait_drain();
        keep_a = 1'b0;
        check("keep_a_retained", a_mat, ID_MAT);
        for (int i = 0; i < 16; i++) B_m[i] = 8'h05;
        load(0);
        wait_drain();
        check("keep_a_result", obs_p, {16{8'h05}});

        // Reset after 20 input bytes, then a full identity job
        set_id_ramp();
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midload_rst_a", a_mat, '0);
        check("midload_rst_b", b_mat, '0);
        check("midload_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        load(1);
        wait_drain();
        check("after_midload_rst", obs_p, RAMP_MAT);

        // Reset during drain
        load(1);
        t = 0;
        while (out_pos < 5 && t < 200) begin @(posedge clk); t++; end
        check("reach_mid_drain", out_pos >= 5, 1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        out_pos = 0;
        check("drain_rst_out_valid", out_valid, 0);
        check("drain_rst_in_ready", in_ready, 1);
        check("drain_rst_busy", busy, 0);
        check("drain_rst_out_data", out_data, 0);
        rst_n = 1'b1;

        // CALC_CYCLES=4 instance
        for (int i = 0; i < 16; i++) begin
            A_m[i] = (i % 5 == 0) ? 8'h01 : 8'h00;
            B_m[i] = 8'(i * 7 + 3);
        end
        out_ready4 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data4  = (i < 16) ? A_m[i] : B_m[i-16];
            in_valid4 = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready4 && t < 200) begin @(negedge clk); t++; end
            if (!in_ready4) check("in_ready4_timeout", in_ready4, 1);
            last_hs = cyc;
            @(posedge clk);
            #1;
            in_valid4 = 1'b0;
        end
        t = 0;
        @(negedge clk);
        while (!out_valid4 && t < 100) begin
            check("in_ready4_low_calc", in_ready4, 0);
            @(negedge clk);
            t++;
        end
        check("latency4", cyc - last_hs, 5);
        obs4 = '0;
        for (int i = 0; i < 16; i++) begin
            check("out_valid4_stream", out_valid4, 1);
            check("out_last4", out_last4, i == 15);
            obs4[127-8*i -: 8] = out_data4;
            @(negedge clk);
        end
        check("out_valid4_done", out_valid4, 0);
        check("result4_model", obs4, model_product());
        check("result4_literal", obs4, 128'h030a1118_1f262d34_3b424950_575e656c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
